// File: rtl/lane_collector.sv
// Collects strobed demux lanes into one-entry slots and drains them round-robin
// onto a valid/ready byte output. Optional overflow flags: LANE_COLLECTOR_OVF_EN.
module lane_collector (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] C,
    input  logic [7:0] D,
    input  logic [1:0] sel,
    input  logic       wr_en,
    output logic [7:0] out_data,
    output logic [1:0] out_lane,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] pending,
    output logic [3:0] ovf,
    input  logic       ovf_clr
);

    logic [7:0] slot_data [4];
    logic [3:0] slot_vld;
    logic [1:0] rr;

    logic       grant;
    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [1:0] idx;
    logic [7:0] wr_data;
    logic       wr_ok;
    logic       drop;
    logic [3:0] vld_nxt;

    // Round-robin search starting at rr; a slot being granted may be rewritten
    // in the same cycle, which is why the write check looks at the grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr;
        idx       = rr;
        for (int k = 0; k < 4; k++) begin
            idx = rr + k[1:0];
            if (!gnt_found && slot_vld[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        grant = gnt_found && (!out_valid || out_ready);

        case (sel)
            2'd0:    wr_data = A;
            2'd1:    wr_data = B;
            2'd2:    wr_data = C;
            default: wr_data = D;
        endcase

        wr_ok = wr_en && (!slot_vld[sel] || (grant && (gnt_idx == sel)));
        drop  = wr_en && !wr_ok;

        vld_nxt = slot_vld;
        if (grant) begin
            vld_nxt[gnt_idx] = 1'b0;
        end
        if (wr_ok) begin
            vld_nxt[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                slot_data[i] <= 8'h00;
            end
            slot_vld  <= 4'b0000;
            rr        <= 2'd0;
            pending   <= 3'd0;
            out_data  <= 8'h00;
            out_lane  <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            slot_vld <= vld_nxt;
            if (wr_ok) begin
                slot_data[sel] <= wr_data;
            end
            pending <= {2'b00, vld_nxt[0]} + {2'b00, vld_nxt[1]}
                     + {2'b00, vld_nxt[2]} + {2'b00, vld_nxt[3]};
            if (grant) begin
                out_data  <= slot_data[gnt_idx];
                out_lane  <= gnt_idx;
                out_valid <= 1'b1;
                rr        <= gnt_idx + 2'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef LANE_COLLECTOR_OVF_EN
    logic [3:0] drop_vec;

    assign drop_vec = drop ? (4'b0001 << sel) : 4'b0000;

    // A fresh overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 4'b0000;
        end else begin
            ovf <= (ovf_clr ? 4'b0000 : ovf) | drop_vec;
        end
    end
`else
    logic unused_ovf_inputs;

    assign unused_ovf_inputs = ovf_clr | drop;
    assign ovf               = 4'b0000;
`endif

endmodule
